// File: rtl/delta_lif_pkg.sv
// delta_lif_pkg: definitions shared by the delta-LIF neuron array and its event FIFO.
//   - default parameter constants
//   - FSM state encoding (IDLE, SCAN)
//   - event record layout helpers; a record is {chan, sign, mag}, with mag in the LSBs
package delta_lif_pkg;

    localparam int unsigned DEF_NUM_CH     = 4;
    localparam int unsigned DEF_WIDTH      = 8;
    localparam int unsigned DEF_SPIKE_TH   = 200;
    localparam int unsigned DEF_DELTA_TH   = 50;
    localparam int unsigned DEF_LEAK_SHIFT = 1;
    localparam int unsigned DEF_REFRAC     = 2;
    localparam int unsigned DEF_FIFO_DEPTH = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } fsm_state_e;

    // The magnitude field starts at bit 0.
    localparam int unsigned EV_MAG_LSB = 0;

    // Width of the channel index. It is never narrower than one bit.
    function automatic int unsigned chan_w(input int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // The sign bit sits directly above the magnitude.
    function automatic int unsigned ev_sign_bit(input int unsigned width);
        return EV_MAG_LSB + width;
    endfunction

    // The channel field sits above the sign bit.
    function automatic int unsigned ev_chan_lsb(input int unsigned width);
        return EV_MAG_LSB + width + 1;
    endfunction

    // Total width of one event record.
    function automatic int unsigned ev_rec_w(input int unsigned width, input int unsigned cw);
        return cw + 1 + width;
    endfunction

endpackage

// File: rtl/delta_event_fifo.sv
// delta_event_fifo: first-word-fall-through FIFO for the delta-event records.
//   clk, rst          : clock and async active-high reset (clears the pointers and the count)
//   push, push_data   : write request and its data; the write is accepted when not full
//                       or when a pop happens in the same cycle
//   full              : FIFO holds DEPTH entries
//   pop, pop_data     : read request and the head entry; the head is visible while not empty
//   empty             : FIFO holds no entries
module delta_event_fifo
    import delta_lif_pkg::*;
#(
    parameter int unsigned DEPTH  = DEF_FIFO_DEPTH,
    parameter int unsigned DATA_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic              full,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_do_push;
    logic              w_do_pop;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
    assign w_do_pop  = pop && (r_count != '0);
    assign w_do_push = push && ((r_count != CW'(DEPTH)) || w_do_pop);

    assign full     = (r_count == CW'(DEPTH));
    assign empty    = (r_count == '0);
    assign pop_data = r_mem[r_rd_ptr];

    // Storage array. It is not reset, because reading is qualified by empty.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy. DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/delta_lif_array.sv
// delta_lif_array: an array of leaky integrate-and-fire neurons with delta-event output.
//   clk, rst         : clock and async active-high reset
//   in_valid/ready   : handshake for one timestep of currents; ready is high only in IDLE
//   in_current       : unsigned per-channel currents; channel k is at [k*WIDTH +: WIDTH]
//   state_out        : membrane states, packed the same way
//   spike            : per-channel spike flags, held until the next accepted step
//   ev_valid/ready   : delta-event stream taken from the FIFO head
//   ev_chan/sign/mag : event channel, direction (1 = decrease) and magnitude
//   ev_overflow      : sticky flag, set when an event is dropped because the FIFO is full
// Each accepted step updates every channel at once. The block then scans one channel
// per cycle and emits an event when a state has moved by DELTA_TH or more since the
// last value sent for that channel.
module delta_lif_array
    import delta_lif_pkg::*;
#(
    parameter int unsigned NUM_CH     = DEF_NUM_CH,
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned SPIKE_TH   = DEF_SPIKE_TH,
    parameter int unsigned DELTA_TH   = DEF_DELTA_TH,
    parameter int unsigned LEAK_SHIFT = DEF_LEAK_SHIFT,
    parameter int unsigned REFRAC     = DEF_REFRAC,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_CH*WIDTH-1:0]   in_current,
    output logic [NUM_CH*WIDTH-1:0]   state_out,
    output logic [NUM_CH-1:0]         spike,
    output logic                      ev_valid,
    input  logic                      ev_ready,
    output logic [chan_w(NUM_CH)-1:0] ev_chan,
    output logic                      ev_sign,
    output logic [WIDTH-1:0]          ev_mag,
    output logic                      ev_overflow
);

    localparam int unsigned CH_W     = chan_w(NUM_CH);
    localparam int unsigned SW       = WIDTH + 1;
    localparam int unsigned EV_W     = ev_rec_w(WIDTH, CH_W);
    localparam int unsigned SIGN_BIT = ev_sign_bit(WIDTH);
    localparam int unsigned CHAN_LSB = ev_chan_lsb(WIDTH);
    localparam int unsigned RF_W     = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

    fsm_state_e r_fsm;
    fsm_state_e w_fsm_nxt;
    logic       w_accept;
    logic       w_scan_last;

    logic [CH_W-1:0] r_scan_idx;
    logic            r_in_ready;
    logic            r_overflow;

    logic [NUM_CH*WIDTH-1:0] w_state_flat;
    logic [NUM_CH*WIDTH-1:0] w_last_tx_flat;
    logic [NUM_CH-1:0]       w_spike_flat;

    logic [WIDTH-1:0] w_scan_state;
    logic [WIDTH-1:0] w_scan_last_tx;
    logic [SW-1:0]    w_diff;
    logic             w_neg;
    logic [WIDTH-1:0] w_mag;
    logic             w_need;
    logic             w_push;
    logic             w_pop;
    logic             w_drop;
    logic [EV_W-1:0]  w_push_data;
    logic [EV_W-1:0]  w_pop_data;
    logic             w_full;
    logic             w_empty;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm <= ST_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    // Next state. The scan visits channels 0..NUM_CH-1 and then returns to IDLE.
    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_accept    = 1'b0;
        w_scan_last = (r_scan_idx == CH_W'(NUM_CH - 1));
        case (r_fsm)
            ST_IDLE: begin
                if (in_valid) begin
                    w_accept  = 1'b1;
                    w_fsm_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (w_scan_last) begin
                    w_fsm_nxt = ST_IDLE;
                end
            end
            default: w_fsm_nxt = ST_IDLE;
        endcase
    end

    // Control registers: registered ready, scan index and the sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_ready <= 1'b1;
            r_scan_idx <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_in_ready <= (w_fsm_nxt == ST_IDLE);
            if (w_accept) begin
                r_scan_idx <= '0;
            end else if (r_fsm == ST_SCAN) begin
                r_scan_idx <= r_scan_idx + CH_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Per-channel neuron: leak plus integrate on accept, and refractory hold after a spike.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [WIDTH-1:0] r_state;
        logic [WIDTH-1:0] r_last_tx;
        logic [RF_W-1:0]  r_refrac;
        logic             r_spike;
        logic [WIDTH-1:0] w_cur;
        logic [SW-1:0]    w_sum;
        logic [WIDTH-1:0] w_next;
        logic             w_fire;
        logic             w_sel;

        assign w_cur  = in_current[k*WIDTH +: WIDTH];
        // s - (s >> LEAK_SHIFT) never goes below zero, so one extra bit holds the sum.
        assign w_sum  = SW'(r_state) - SW'(r_state >> LEAK_SHIFT) + SW'(w_cur);
        assign w_next = w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0];
        assign w_fire = (32'(w_next) >= SPIKE_TH);
        assign w_sel  = (r_fsm == ST_SCAN) && (r_scan_idx == CH_W'(k));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state   <= '0;
                r_last_tx <= '0;
                r_refrac  <= '0;
                r_spike   <= 1'b0;
            end else begin
                if (w_accept) begin
                    if (r_refrac != '0) begin
                        r_state  <= '0;
                        r_refrac <= r_refrac - RF_W'(1);
                        r_spike  <= 1'b0;
                    end else if (w_fire) begin
                        r_state  <= '0;
                        r_refrac <= RF_W'(REFRAC);
                        r_spike  <= 1'b1;
                    end else begin
                        r_state  <= w_next;
                        r_spike  <= 1'b0;
                    end
                end
                // Track only what was actually sent, so a dropped event is retried later.
                if (w_push && w_sel) begin
                    r_last_tx <= r_state;
                end
            end
        end

        assign w_state_flat[k*WIDTH +: WIDTH]   = r_state;
        assign w_last_tx_flat[k*WIDTH +: WIDTH] = r_last_tx;
        assign w_spike_flat[k]                  = r_spike;
    end

    // Select the channel under scan.
    always_comb begin
        w_scan_state   = '0;
        w_scan_last_tx = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (r_scan_idx == CH_W'(k)) begin
                w_scan_state   = w_state_flat[k*WIDTH +: WIDTH];
                w_scan_last_tx = w_last_tx_flat[k*WIDTH +: WIDTH];
            end
        end
    end

    // Signed change since the last value sent. An event is pushed if space exists or a pop frees it.
    assign w_diff      = SW'(w_scan_state) - SW'(w_scan_last_tx);
    assign w_neg       = w_diff[WIDTH];
    assign w_mag       = w_neg ? WIDTH'(SW'(0) - w_diff) : w_diff[WIDTH-1:0];
    assign w_need      = (r_fsm == ST_SCAN) && (32'(w_mag) >= DELTA_TH);
    assign w_pop       = !w_empty && ev_ready;
    assign w_push      = w_need && (!w_full || w_pop);
    assign w_drop      = w_need && w_full && !w_pop;
    assign w_push_data = {r_scan_idx, w_neg, w_mag};

    delta_event_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (EV_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_data),
        .full      (w_full),
        .pop       (w_pop),
        .pop_data  (w_pop_data),
        .empty     (w_empty)
    );

    assign in_ready    = r_in_ready;
    assign state_out   = w_state_flat;
    assign spike       = w_spike_flat;
    assign ev_overflow = r_overflow;
    assign ev_valid    = !w_empty;
    // The event fields are forced to zero while there is no valid head.
    assign ev_chan     = w_empty ? '0   : w_pop_data[CHAN_LSB +: CH_W];
    assign ev_sign     = w_empty ? 1'b0 : w_pop_data[SIGN_BIT];
    assign ev_mag      = w_empty ? '0   : w_pop_data[EV_MAG_LSB +: WIDTH];

endmodule

// File: tb/tb_delta_lif_array.sv
// tb_delta_lif_array: directed, scoreboard-checked bench for delta_lif_array.
module tb_delta_lif_array;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned WIDTH  = 8;
    localparam int unsigned CH_W   = 2;
    localparam int unsigned EV_W   = CH_W + 1 + WIDTH;
    localparam int unsigned CYC    = NUM_CH + 1;

    logic                    clk;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_CH*WIDTH-1:0] in_current;
    logic [NUM_CH*WIDTH-1:0] state_out;
    logic [NUM_CH-1:0]       spike;
    logic                    ev_valid;
    logic                    ev_ready;
    logic [CH_W-1:0]         ev_chan;
    logic                    ev_sign;
    logic [WIDTH-1:0]        ev_mag;
    logic                    ev_overflow;

    int checks   = 0;
    int failures = 0;
    logic [EV_W-1:0] exp_q [$];

    delta_lif_array dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_current  (in_current),
        .state_out   (state_out),
        .spike       (spike),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_chan     (ev_chan),
        .ev_sign     (ev_sign),
        .ev_mag      (ev_mag),
        .ev_overflow (ev_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pk(input int c0, input int c1, input int c2, input int c3);
        return {8'(c3), 8'(c2), 8'(c1), 8'(c0)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic exp_ev(input int c, input int s, input int m);
        exp_q.push_back({2'(c), 1'(s), 8'(m)});
    endtask

    // Monitor: every handshaked event is compared against the head of the expected queue.
    always @(negedge clk) begin
        logic [EV_W-1:0] e;
        if (!rst && ev_valid && ev_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL ev_unexpected actual=ch%0d sign%0d mag%0d required=none",
                         ev_chan, ev_sign, ev_mag);
            end else begin
                e = exp_q.pop_front();
                if ({ev_chan, ev_sign, ev_mag} !== e) begin
                    failures++;
                    $display("FAIL ev_record actual=ch%0d sign%0d mag%0d required=ch%0d sign%0d mag%0d",
                             ev_chan, ev_sign, ev_mag, e[10:9], e[8], e[7:0]);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One timestep: wait for ready, accept, check the new state/spike, then let the scan complete.
    task automatic do_step(input logic [31:0] cur, input logic [31:0] exp_state,
                           input logic [3:0] exp_spike, input logic rdy_after, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL %s_ready_timeout actual=0 required=1", tag);
        end
        in_valid   = 1'b1;
        in_current = cur;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        in_current = 32'hA5A5_A5A5;
        ev_ready   = rdy_after;
        check({tag, "_state"}, state_out, exp_state);
        check({tag, "_spike"}, 32'(spike), 32'(exp_spike));
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
        repeat (NUM_CH) @(posedge clk);
        #1;
        check({tag, "_idle"}, 32'(in_ready), 32'd1);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        ev_ready = 1'b1;
        while ((exp_q.size() != 0 || ev_valid) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain_left"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_drain_valid"}, 32'(ev_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b0;
        in_valid   = 1'b0;
        in_current = '0;
        ev_ready   = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_ev_valid", 32'(ev_valid), 32'd0);
        check("rst_state", state_out, 32'd0);
        check("rst_spike", 32'(spike), 32'd0);
        check("rst_ev_fields", {21'd0, ev_chan, ev_sign, ev_mag}, 32'd0);
        check("rst_overflow", 32'(ev_overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Leak/decay on ch0, spike and refractory on ch1, saturating sum on ch3.
        ev_ready = 1'b1;
        exp_ev(0, 0, 60); exp_ev(1, 0, 120); exp_ev(3, 0, 150);
        do_step(pk(60, 120, 0, 150), pk(60, 120, 0, 150), 4'b0000, 1'b1, "s1");
        exp_ev(1, 0, 60); exp_ev(3, 1, 150);
        do_step(pk(0, 120, 0, 255), pk(30, 180, 0, 0), 4'b1000, 1'b1, "s2");
        exp_ev(1, 1, 180);
        do_step(pk(0, 120, 0, 0), pk(15, 0, 0, 0), 4'b0010, 1'b1, "s3");
        exp_ev(0, 1, 52);
        do_step(pk(0, 0, 0, 0), pk(8, 0, 0, 0), 4'b0000, 1'b1, "s4");
        exp_ev(3, 0, 120);
        do_step(pk(0, 120, 0, 120), pk(4, 0, 0, 120), 4'b0000, 1'b1, "s5");
        exp_ev(1, 0, 120); exp_ev(3, 1, 60);
        do_step(pk(0, 120, 0, 0), pk(2, 120, 0, 60), 4'b0000, 1'b1, "s6");
        drain("seq1");
        check("seq1_overflow", 32'(ev_overflow), 32'd0);

        // Fill the FIFO, then drop a whole step of events.
        do_reset();
        ev_ready = 1'b0;
        for (int k = 0; k < 4; k++) exp_ev(k, 0, 100);
        do_step(pk(100, 100, 100, 100), pk(100, 100, 100, 100), 4'b0000, 1'b0, "fill");
        check("fill_overflow", 32'(ev_overflow), 32'd0);
        check("fill_valid", 32'(ev_valid), 32'd1);
        do_step(pk(150, 150, 150, 150), pk(0, 0, 0, 0), 4'b1111, 1'b0, "drop");
        check("drop_overflow", 32'(ev_overflow), 32'd1);
        drain("drop");
        check("drop_overflow_sticky", 32'(ev_overflow), 32'd1);

        // Full FIFO with a simultaneous pop: every push must be accepted.
        do_reset();
        ev_ready = 1'b0;
        for (int k = 0; k < 4; k++) exp_ev(k, 0, 100);
        do_step(pk(100, 100, 100, 100), pk(100, 100, 100, 100), 4'b0000, 1'b0, "full");
        for (int k = 0; k < 4; k++) exp_ev(k, 0, 50);
        do_step(pk(100, 100, 100, 100), pk(150, 150, 150, 150), 4'b0000, 1'b1, "pp");
        check("pp_overflow", 32'(ev_overflow), 32'd0);
        drain("pp");

        // Reset in the middle of a scan while two events are queued.
        do_reset();
        ev_ready = 1'b0;
        @(negedge clk);
        in_valid   = 1'b1;
        in_current = pk(60, 120, 0, 0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("mid_pre_valid", 32'(ev_valid), 32'd1);
        check("mid_pre_head", {21'd0, ev_chan, ev_sign, ev_mag}, 32'd60);
        check("mid_pre_busy", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("mid_state", state_out, 32'd0);
        check("mid_spike", 32'(spike), 32'd0);
        check("mid_ready", 32'(in_ready), 32'd1);
        check("mid_ev_valid", 32'(ev_valid), 32'd0);
        check("mid_ev_fields", {21'd0, ev_chan, ev_sign, ev_mag}, 32'd0);
        check("mid_overflow", 32'(ev_overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ev_ready = 1'b1;
        repeat (8) @(negedge clk);
        check("mid_post_valid", 32'(ev_valid), 32'd0);

        // in_valid held high: an accept every NUM_CH+1 cycles.
        do_reset();
        ev_ready   = 1'b1;
        in_current = '0;
        @(negedge clk);
        in_valid = 1'b1;
        for (int n = 0; n < 3 * CYC; n++) begin
            check($sformatf("cont_ready_%0d", n), 32'(in_ready), (n % CYC == 0) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("cont_state", state_out, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
